// File: rtl/key_event_queue.sv
// Key event serializer: pending vector, priority scheduler and FWFT event FIFO.
// Optional typematic auto-repeat is compiled in with `define KEY_REPEAT_EN.
module key_event_queue #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int REPEAT_DLY = 6000000,
    parameter int REPEAT_PER = 1200000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   key_out,
    input  logic [15:0]   key_pulse,
    output logic          evt_valid,
    output logic [3:0]    evt_code,
    output logic          evt_rel,
    input  logic          evt_ready,
    output logic [AW:0]   level,
    output logic          ovf,
    input  logic          ovf_clr
);

    logic [15:0] kd;
    logic [31:0] pend;
    logic [31:0] set_v;
    logic [31:0] clr_v;
    logic [15:0] rpt_set;
    logic [4:0]  sel;
    logic        have;
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] cnt;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    logic [4:0]  mem [DEPTH];
    logic [4:0]  head;

    // Lowest set bit wins: presses before releases, low keys first.
    always_comb begin
        sel = '0;
        for (int i = 31; i >= 0; i--) begin
            if (pend[i]) sel = 5'(i);
        end
    end

    assign have  = |pend;
    assign cnt   = wptr - rptr;
    assign level = cnt;
    assign full  = (cnt == (AW+1)'(DEPTH));

    assign evt_valid = (cnt != '0);
    assign pop       = evt_valid & evt_ready;
    assign push      = have & (~full | pop);

    assign clr_v = push ? (32'd1 << sel) : 32'd0;
    assign set_v = {kd & ~key_out, key_pulse | rpt_set};

    // A set on a bit that is waiting but not leaving this cycle is lost.
    assign drop = |(set_v & pend & ~clr_v);

    assign head     = mem[rptr[AW-1:0]];
    assign evt_code = evt_valid ? head[3:0] : 4'd0;
    assign evt_rel  = evt_valid & head[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kd   <= '0;
            pend <= '0;
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            kd   <= key_out;
            pend <= (pend & ~clr_v) | set_v;
            if (push) begin
                mem[wptr[AW-1:0]] <= sel;
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    logic        rpt_act;
    logic [3:0]  rpt_code;
    logic [3:0]  new_code;
    logic [31:0] rpt_cnt;
    logic        rpt_fire;

    always_comb begin
        new_code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (key_pulse[i]) new_code = 4'(i);
        end
    end

    assign rpt_fire = rpt_act & (rpt_cnt == 32'd1) & key_out[rpt_code];
    assign rpt_set  = rpt_fire ? (16'd1 << rpt_code) : 16'd0;

    // A fresh press always retargets; otherwise count down while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_act  <= 1'b0;
            rpt_code <= '0;
            rpt_cnt  <= '0;
        end else if (|key_pulse) begin
            rpt_act  <= 1'b1;
            rpt_code <= new_code;
            rpt_cnt  <= 32'(REPEAT_DLY);
        end else if (rpt_act) begin
            if (!key_out[rpt_code]) begin
                rpt_act <= 1'b0;
            end else if (rpt_cnt == 32'd1) begin
                rpt_cnt <= 32'(REPEAT_PER);
            end else begin
                rpt_cnt <= rpt_cnt - 32'd1;
            end
        end
    end
`else
    logic [63:0] unused_rpt;

    assign rpt_set    = '0;
    assign unused_rpt = {32'(REPEAT_DLY), 32'(REPEAT_PER)};
`endif

endmodule

// File: doc/key_event_queue.md
# key_event_queue

Sits between `Array_KeyBoard` and the consumer logic, such as a UART sender or a display driver. Every cycle it takes the scanner's per-key press pulses and level states and turns them into a serialized stream of encoded key events (key code plus a press/release flag). Simultaneous events are buffered without loss, and the consumer reads them through a valid/ready handshake. An optional typematic auto-repeat generator is also available.

## Interface
Parameters:
- `DEPTH`, 8: event FIFO entries; must be a power of two, 2..64.
- `AW`, 3: FIFO address width; must equal log2(`DEPTH`).
- `REPEAT_DLY`, 6000000: cycles from a press to the first repeat (500 ms at 12 MHz).
- `REPEAT_PER`, 1200000: cycles between subsequent repeats (100 ms).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous assert, active-low, applies to all state.
- `key_out` in 16: debounced key levels from the scanner; 1 = held.
- `key_pulse` in 16: one-cycle press pulses from the scanner.
- `evt_valid` out 1: FIFO head is valid.
- `evt_code` out 4: key index 0..15 of the head event.
- `evt_rel` out 1: 1 = release event, 0 = press or repeat event.
- `evt_ready` in 1: consumer accepts the head event.
- `level` out AW+1: current FIFO occupancy, 0..`DEPTH`.
- `ovf` out 1: sticky flag, set when an event is dropped.
- `ovf_clr` in 1: clears `ovf`.

## Operation
- Release detection: `key_out` is registered as `kd`. Bit i is a release when `kd[i]`=1 and `key_out[i]`=0.
- Pending vector `pend[31:0]`:
  - Bits 0..15 are press events, set by `key_pulse[i]` or by the repeat generator.
  - Bits 16..31 are release events.
  - Bits stay set until serviced, and events are never lost while they wait.
- Scheduler:
  - Combinationally selects the lowest set bit of `pend`, so presses outrank releases and lower keys outrank higher keys.
  - Writes one entry per cycle, `{rel, code}`, into the FIFO when a push is allowed, then clears that `pend` bit.
- Push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- When a pending bit is being serviced and a new set arrives for the same bit in the same cycle, the bit stays set. The new event is queued next; `ovf` is not set.
- When a set arrives for a bit that is already pending and not being serviced, the new event is dropped and `ovf` is set.
- FIFO behaviour:
  - First-word fall-through: `evt_valid` = (`level` != 0), and `evt_code`/`evt_rel` show the head entry.
  - A pop happens on `evt_valid` & `evt_ready`. Asserting `evt_ready` while the FIFO is empty has no effect.
  - Pointers are AW+1 bits and wrap naturally.
- `ovf`: `ovf_clr` clears it; a set in the same cycle takes priority over the clear.

## Timing
- Reset values:
  - Outputs: `evt_valid`=0, `evt_code`=0, `evt_rel`=0, `level`=0, `ovf`=0.
  - Internal: `pend`=0, `kd`=0, pointers=0, repeat counter idle.
- Press latency:
  - `key_pulse[i]` high in cycle N sets `pend[i]` at edge N+1.
  - The FIFO write happens at edge N+2.
  - `evt_valid` rises after edge N+2 if the FIFO was empty and no other event had higher priority.
- Release latency: the same two edges, counted from the first cycle `key_out[i]` is low.
- Throughput: at most one push and one pop per cycle. K simultaneous events drain in K cycles.
- `level` updates at the push/pop edge:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Reset asserted mid-operation discards all queued and pending events immediately; the consumer sees `evt_valid` fall asynchronously.
- The handshake holds the head stable: while `evt_valid`=1 and `evt_ready`=0, `evt_code` and `evt_rel` do not change.

## Configuration
- Macro `KEY_REPEAT_EN`.
- When defined:
  - A press tracker latches the code of the most recent press (from `key_pulse`) and loads a counter with `REPEAT_DLY`.
  - When the counter expires and `key_out[code]` is still 1, it sets `pend[code]`, producing a press event with `evt_rel`=0. It then reloads with `REPEAT_PER`.
  - The tracker goes idle when `key_out[code]` falls. A new press retargets it and restarts the delay.
  - Counter width is 32 bits.
- When undefined: no tracker or counter is synthesized, the `REPEAT_*` parameters are ignored, and only `key_pulse`-driven presses and releases are produced.

## Test plan
- Single key: `key_pulse`=16'h0004 for one cycle, `key_out[2]` high for 100 cycles, `evt_ready`=1 → press event `evt_code`=2, `evt_rel`=0 two edges after the pulse, then release event `evt_code`=2, `evt_rel`=1 two edges after `key_out[2]` falls. `level` returns to 0.
- Simultaneous presses: `key_pulse`=16'h8421 in one cycle, `evt_ready`=0 → `level` climbs to 4 and codes pop in order 0, 5, 10, 15 once `evt_ready`=1.
- Overflow:
  - `DEPTH`=8, `evt_ready`=0, then 12 single-key pulses on distinct keys.
  - → `level`=8 and 4 events wait in `pend`, with `ovf`=0.
  - Re-pulsing one of the waiting keys → `ovf`=1.
  - `ovf_clr` → `ovf`=0.
  - Draining yields all 12 events in priority order.
- Full with simultaneous push and pop: with the FIFO full and `pend` non-empty, hold `evt_ready`=1 → one event in and one out per cycle, with `level` held at 8.
- Reset mid-stream: assert `rst_n`=0 with `level`=5 → `evt_valid`=0 and `level`=0 without waiting for a clock edge. After release, no stale events appear.
- Repeat (`KEY_REPEAT_EN`, `REPEAT_DLY`=20, `REPEAT_PER`=10): hold key 7 for 55 cycles → press events at +2, +22, +32, +42, +52, then one release. Without the macro: one press and one release only.
